// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared types, segment constants and decode helpers for the lap stopwatch
package stopwatch_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} sw_state_e;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef struct packed {
        logic [6:0] min;
        logic [5:0] sec;
        logic [6:0] hund;
    } sw_time_t;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Returns {tens, ones} segment patterns for a 0..99 field.
    function automatic logic [13:0] seg_pair(input logic [6:0] v);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'(v / 7'd10);
        ones = 4'(v % 7'd10);
        return {seg7(tens), seg7(ones)};
    endfunction

endpackage

// File: rtl/sw_tick_gen.sv
// rtl/sw_tick_gen.sv - run-gated tick divider; STOPWATCH_QUICK_EN enables the quick speed-up shift
module sw_tick_gen #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    input  logic [3:0] quick,
    output logic       tick
);
    localparam int          BASE_I = (CLK_HZ / TICK_HZ < 1) ? 1 : CLK_HZ / TICK_HZ;
    localparam logic [31:0] BASE   = 32'(BASE_I);

    logic [31:0] cnt;
    logic [31:0] div;

`ifdef STOPWATCH_QUICK_EN
    logic [31:0] div_next;

    always_comb begin
        div_next = BASE >> quick;
        if (div_next == 32'd0)
            div_next = 32'd1;
    end

    // Divisor is reloaded only at a wrap (or while idle) so the counter never overshoots it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            div <= BASE;
        else if (clr || tick)
            div <= div_next;
    end
`else
    logic unused_quick;
    assign unused_quick = ^quick;
    assign div          = BASE;
`endif

    assign tick = en && (cnt == div - 32'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= tick ? 32'd0 : cnt + 32'd1;
    end

endmodule

// File: rtl/stopwatch_lap.sv
// rtl/stopwatch_lap.sv - MM:SS.hh stopwatch with start/pause/clear FSM, circular lap buffer and 7-seg outputs
module stopwatch_lap
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int TICK_HZ   = 100,
    parameter int MIN_MAX   = 99,
    parameter int LAP_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_stop,
    input  logic                         lap_clr,
    input  logic [3:0]                   quick,
    input  logic                         lap_view,
    input  logic [$clog2(LAP_DEPTH)-1:0] lap_idx,
    output logic [6:0]                   seg_s001,
    output logic [6:0]                   seg_s01,
    output logic [6:0]                   seg_s1,
    output logic [6:0]                   seg_s10,
    output logic [6:0]                   seg_m1,
    output logic [6:0]                   seg_m10,
    output logic                         running,
    output logic [$clog2(LAP_DEPTH):0]   lap_cnt,
    output logic                         ovf
);
    localparam int         IW   = $clog2(LAP_DEPTH);
    localparam logic [6:0] MINV = 7'(MIN_MAX);

    sw_state_e   state;
    logic        ss_q, lc_q;
    logic        ss_p, lc_p;
    logic        lap_take, clear, tick;
    sw_time_t    tm, shown;
    sw_time_t    lap_mem [LAP_DEPTH];
    logic [IW-1:0] wptr, rd_ptr;
    logic        show_lap;

    assign ss_p     = start_stop & ~ss_q;
    assign lc_p     = lap_clr & ~lc_q & ~ss_p;   // start_stop wins a tie
    assign lap_take = (state == RUN) && lc_p;
    assign clear    = (state == PAUSE) && lc_p;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            running <= 1'b0;
            ss_q    <= 1'b0;
            lc_q    <= 1'b0;
        end else begin
            ss_q <= start_stop;
            lc_q <= lap_clr;
            case (state)
                IDLE:    if (ss_p) begin state <= RUN;   running <= 1'b1; end
                RUN:     if (ss_p) begin state <= PAUSE; running <= 1'b0; end
                PAUSE:   if (ss_p) begin state <= RUN;   running <= 1'b1; end
                         else if (lc_p) state <= IDLE;
                default: begin state <= IDLE; running <= 1'b0; end
            endcase
        end
    end

    sw_tick_gen #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) u_tick (
        .clk   (clk),
        .rst   (rst),
        .en    (state == RUN),
        .clr   (state == IDLE),
        .quick (quick),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tm      <= '0;
            ovf     <= 1'b0;
            wptr    <= '0;
            lap_cnt <= '0;
        end else if (clear) begin
            tm      <= '0;
            ovf     <= 1'b0;
            wptr    <= '0;
            lap_cnt <= '0;
        end else begin
            if (lap_take) begin
                wptr <= wptr + IW'(1);
                if (lap_cnt != (IW+1)'(LAP_DEPTH))
                    lap_cnt <= lap_cnt + (IW+1)'(1);
            end
            if (tick) begin
                if (tm.hund != 7'd99) begin
                    tm.hund <= tm.hund + 7'd1;
                end else begin
                    tm.hund <= '0;
                    if (tm.sec != 6'd59) begin
                        tm.sec <= tm.sec + 6'd1;
                    end else begin
                        tm.sec <= '0;
                        if (tm.min != MINV) begin
                            tm.min <= tm.min + 7'd1;
                        end else begin
                            tm.min <= '0;
                            ovf    <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Lap holds the pre-increment time even when a tick lands on the same edge.
    always_ff @(posedge clk) begin
        if (lap_take)
            lap_mem[wptr] <= tm;
    end

    assign rd_ptr   = IW'(wptr - IW'(1) - lap_idx);
    assign show_lap = (state == PAUSE) && lap_view && ({1'b0, lap_idx} < lap_cnt);
    assign shown    = show_lap ? lap_mem[rd_ptr] : tm;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {seg_m10, seg_m1}   <= {SEG_0, SEG_0};
            {seg_s10, seg_s1}   <= {SEG_0, SEG_0};
            {seg_s01, seg_s001} <= {SEG_0, SEG_0};
        end else begin
            {seg_m10, seg_m1}   <= seg_pair(shown.min);
            {seg_s10, seg_s1}   <= seg_pair({1'b0, shown.sec});
            {seg_s01, seg_s001} <= seg_pair(shown.hund);
        end
    end

endmodule

// File: tb/tb_stopwatch_lap.sv
// tb/tb_stopwatch_lap.sv - self-checking bench for stopwatch_lap (main instance DIV=10, overflow instance DIV=1, MIN_MAX=1)
module tb_stopwatch_lap;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       ss1, lc1, ss2, lc2;
    logic [3:0] quick;
    logic       view;
    logic [1:0] idx;

    logic [6:0] a_s001, a_s01, a_s1, a_s10, a_m1, a_m10;
    logic       a_run, a_ovf;
    logic [2:0] a_cnt;
    logic [6:0] b_s001, b_s01, b_s1, b_s10, b_m1, b_m10;
    logic       b_run, b_ovf;
    logic [2:0] b_cnt;

    stopwatch_lap #(.CLK_HZ(1000), .TICK_HZ(100), .MIN_MAX(99), .LAP_DEPTH(4)) u1 (
        .clk(clk), .rst(rst), .start_stop(ss1), .lap_clr(lc1), .quick(quick),
        .lap_view(view), .lap_idx(idx),
        .seg_s001(a_s001), .seg_s01(a_s01), .seg_s1(a_s1), .seg_s10(a_s10),
        .seg_m1(a_m1), .seg_m10(a_m10), .running(a_run), .lap_cnt(a_cnt), .ovf(a_ovf)
    );

    stopwatch_lap #(.CLK_HZ(100), .TICK_HZ(100), .MIN_MAX(1), .LAP_DEPTH(4)) u2 (
        .clk(clk), .rst(rst), .start_stop(ss2), .lap_clr(lc2), .quick(quick),
        .lap_view(view), .lap_idx(idx),
        .seg_s001(b_s001), .seg_s01(b_s01), .seg_s1(b_s1), .seg_s10(b_s10),
        .seg_m1(b_m1), .seg_m10(b_m10), .running(b_run), .lap_cnt(b_cnt), .ovf(b_ovf)
    );

    function automatic int dig(input logic [6:0] s);
        case (s)
            7'h3F: return 0;
            7'h06: return 1;
            7'h5B: return 2;
            7'h4F: return 3;
            7'h66: return 4;
            7'h6D: return 5;
            7'h7D: return 6;
            7'h07: return 7;
            7'h7F: return 8;
            7'h6F: return 9;
            default: return 99;
        endcase
    endfunction

    int d1, d2;
    assign d1 = dig(a_m10)*100000 + dig(a_m1)*10000 + dig(a_s10)*1000 + dig(a_s1)*100 + dig(a_s01)*10 + dig(a_s001);
    assign d2 = dig(b_m10)*100000 + dig(b_m1)*10000 + dig(b_s10)*1000 + dig(b_s1)*100 + dig(b_s01)*10 + dig(b_s001);

    typedef struct {
        string name;
        int    exp;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic vw;
        logic [1:0] ix;
        int   exp;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic push_exp(input string name, input int v);
        exp_t e;
        e.name = name;
        e.exp  = v;
        sb.push_back(e);
    endtask

    task automatic pop_check(input int act);
        exp_t e;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty actual=%0d", act);
        end else begin
            e = sb.pop_front();
            if (act != e.exp) begin
                n_fail++;
                $display("FAIL %s actual=%0d required=%0d", e.name, act, e.exp);
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        push_exp(name, exp);
        pop_check(act);
    endtask

    task automatic wait_disp(input int unit, input int target, input int budget);
        int k = 0;
        while (((unit == 1) ? d1 : d2) != target && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (((unit == 1) ? d1 : d2) != target) begin
            n_fail++;
            $display("FAIL wait_disp_u%0d actual=%0d required=%0d", unit, (unit == 1) ? d1 : d2, target);
        end
    endtask

    task automatic press(input logic s, input logic l, input int unit);
        if (unit == 1) begin ss1 = s; lc1 = l; end
        else           begin ss2 = s; lc2 = l; end
        @(negedge clk);
        ss1 = 1'b0; lc1 = 1'b0; ss2 = 1'b0; lc2 = 1'b0;
        @(negedge clk);
    endtask

    vec_t vec [5];
    int   laps [5] = '{5, 12, 20, 31, 44};

    initial begin
        vec[0] = '{1'b1, 2'd0, 44};
        vec[1] = '{1'b1, 2'd1, 31};
        vec[2] = '{1'b1, 2'd2, 20};
        vec[3] = '{1'b1, 2'd3, 12};
        vec[4] = '{1'b0, 2'd3, 50};

        rst = 1'b0; ss1 = 0; lc1 = 0; ss2 = 0; lc2 = 0; quick = 4'd0; view = 0; idx = 2'd0;
        repeat (3) @(negedge clk);
        chk("reset_disp_u1", d1, 0);
        chk("reset_seg_s001", int'(a_s001), 'h3F);
        chk("reset_disp_u2", d2, 0);
        chk("reset_running", int'(a_run), 0);
        chk("reset_lap_cnt", int'(a_cnt), 0);
        chk("reset_ovf", int'(a_ovf), 0);
        rst = 1'b1;
        @(negedge clk);

        // Start and run 100 cycles: ten ticks.
        press(1, 0, 1);
        push_exp("run100_disp", 10);
        repeat (100) @(negedge clk);
        pop_check(d1);
        chk("run100_seg_s01", int'(a_s01), 'h06);
        chk("run100_seg_s001", int'(a_s001), 'h3F);
        chk("run100_running", int'(a_run), 1);

        // Pause holds time; resume finishes the partial divider count.
        wait_disp(1, 100, 1200);
        press(1, 0, 1);
        chk("pause_running", int'(a_run), 0);
        push_exp("pause_hold", 100);
        repeat (50) @(negedge clk);
        pop_check(d1);
        press(1, 0, 1);
        chk("resume_running", int'(a_run), 1);
        push_exp("resume_before_tick", 100);
        repeat (7) @(negedge clk);
        pop_check(d1);
        push_exp("resume_partial_tick", 101);
        @(negedge clk);
        pop_check(d1);

        press(1, 0, 1);
        press(0, 1, 1);
        chk("clear_disp", d1, 0);
        chk("clear_running", int'(a_run), 0);

        // Five laps into a 4-deep buffer, then review while paused.
        press(1, 0, 1);
        push_exp("laps_saturate", 4);
        foreach (laps[i]) begin
            wait_disp(1, laps[i], 200);
            press(0, 1, 1);
        end
        pop_check(int'(a_cnt));
        wait_disp(1, 50, 200);
        press(1, 0, 1);
        for (int i = 0; i < 5; i++) begin
            view = vec[i].vw;
            idx  = vec[i].ix;
            push_exp($sformatf("lap_view_%0d", i), vec[i].exp);
            @(negedge clk);
            pop_check(d1);
        end
        view = 1'b0;
        idx  = 2'd0;

        // Clear, one lap, then a simultaneous press pauses without a lap.
        press(0, 1, 1);
        chk("clear2_lap_cnt", int'(a_cnt), 0);
        press(1, 0, 1);
        wait_disp(1, 3, 100);
        press(0, 1, 1);
        wait_disp(1, 9, 100);
        press(1, 1, 1);
        chk("both_running", int'(a_run), 0);
        chk("both_lap_cnt", int'(a_cnt), 1);
        view = 1'b1; idx = 2'd0;
        push_exp("view_idx0", 3);
        @(negedge clk);
        pop_check(d1);
        idx = 2'd1;
        push_exp("view_out_of_range", 9);
        @(negedge clk);
        pop_check(d1);
        view = 1'b0; idx = 2'd0;

        // Quick speed-up.
        press(0, 1, 1);
        quick = 4'd2;
        @(negedge clk);
        press(1, 0, 1);
`ifdef STOPWATCH_QUICK_EN
        push_exp("quick_ticks", 10);
`else
        push_exp("quick_ticks", 2);
`endif
        repeat (20) @(negedge clk);
        pop_check(d1);

        // Asynchronous reset mid-run.
        press(0, 1, 1);
        chk("pre_reset_lap_cnt", int'(a_cnt), 1);
        #2 rst = 1'b0;
        #1;
        chk("async_reset_disp", d1, 0);
        chk("async_reset_running", int'(a_run), 0);
        chk("async_reset_lap_cnt", int'(a_cnt), 0);
        quick = 4'd0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Overflow on the MIN_MAX=1 instance.
        chk("u2_ovf_idle", int'(b_ovf), 0);
        press(1, 0, 2);
        press(0, 1, 2);
        chk("u2_lap_cnt", int'(b_cnt), 1);
        wait_disp(2, 15999, 13000);
        push_exp("u2_wrap_disp", 0);
        @(negedge clk);
        pop_check(d2);
        chk("u2_ovf_set", int'(b_ovf), 1);
        press(1, 0, 2);
        press(0, 1, 2);
        chk("u2_clear_ovf", int'(b_ovf), 0);
        chk("u2_clear_lap_cnt", int'(b_cnt), 0);
        chk("u2_clear_disp", d2, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
